// File: rtl/f_fetch_pc_if.sv
// f_fetch_pc_if: signal bundle between the fetch-PC unit, its control sources
// (CP0, D-stage redirect logic), the instruction memory and the F/D register.
//   Control inputs : WE, Req, eret_D, EPC, jump_D, target_D, branch_D
//   IM bus         : i_inst_addr (to IM), i_inst_rdata (from IM)
//   F/D bundle     : PC_out, Instr_out, ExcCode_out, BD_out
// Modport slave is the fetch-PC unit; modport master is its environment.
interface f_fetch_pc_if;
    logic        WE;
    logic        Req;
    logic        eret_D;
    logic [31:0] EPC;
    logic        jump_D;
    logic [31:0] target_D;
    logic        branch_D;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] PC_out;
    logic [31:0] Instr_out;
    logic [4:0]  ExcCode_out;
    logic        BD_out;

    modport slave (
        input  WE, Req, eret_D, EPC, jump_D, target_D, branch_D, i_inst_rdata,
        output i_inst_addr, PC_out, Instr_out, ExcCode_out, BD_out
    );

    modport master (
        output WE, Req, eret_D, EPC, jump_D, target_D, branch_D, i_inst_rdata,
        input  i_inst_addr, PC_out, Instr_out, ExcCode_out, BD_out
    );
endinterface

// File: rtl/f_fetch_pc.sv
// f_fetch_pc: fetch-stage PC unit of the 5-stage MIPS pipeline.
// Holds the fetch PC, drives the IM address, screens fetches for address errors
// and produces the PC/Instr/ExcCode/BD bundle for the F/D register.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous active-high reset, PC <= RESET_PC
//   bus   : f_fetch_pc_if.slave (control inputs, IM bus, F/D bundle)
// All outputs are combinational from the PC register and current inputs.
module f_fetch_pc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic         clk,
    input  logic         reset,
    f_fetch_pc_if.slave  bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        adel;

    // Exception entry outranks stall; eret outranks a (illegal) simultaneous jump.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (bus.Req) begin
            pc_d = EXC_VECTOR;
        end else if (!bus.WE) begin
            pc_d = pc_q;
        end else if (bus.eret_D) begin
            pc_d = bus.EPC;
        end else if (bus.jump_D) begin
            pc_d = bus.target_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

    // PC_out stays raw on a fault so CP0 can capture the bad address.
    assign bus.i_inst_addr = pc_q;
    assign bus.PC_out      = pc_q;
    assign bus.ExcCode_out = adel ? EXC_ADEL : 5'd0;
    // eret has no delay slot: the word fetched behind it is squashed.
    assign bus.Instr_out   = (adel || bus.eret_D) ? 32'd0 : bus.i_inst_rdata;
    assign bus.BD_out      = bus.branch_D;

endmodule

// File: tb/tb_f_fetch_pc.sv
module tb_f_fetch_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
    } exp_t;

    logic clk;
    logic reset;
    f_fetch_pc_if bus ();

    f_fetch_pc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: a distinct word for every address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    assign bus.i_inst_rdata = imem_word(bus.i_inst_addr);

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          n_checks = 0;
    int          n_passed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs at negedge, score the combinational outputs,
    // then advance the reference PC at the posedge.
    task automatic step(input string tag, input logic rst, input logic req, input logic we,
                        input logic eret, input logic [31:0] epc, input logic jmp,
                        input logic [31:0] tgt, input logic br, input bit chk);
        exp_t e;
        exp_t o;
        logic bad;
        reset        = rst;
        bus.Req      = req;
        bus.WE       = we;
        bus.eret_D   = eret;
        bus.EPC      = epc;
        bus.jump_D   = jmp;
        bus.target_D = tgt;
        bus.branch_D = br;
        if (chk) begin
            bad = (model_pc[1:0] != 2'b00) || (model_pc < 32'h3000) || (model_pc > 32'h6ffc);
            e.pc    = model_pc;
            e.exc   = bad ? 5'd4 : 5'd0;
            e.instr = (bad || eret) ? 32'd0 : imem_word(model_pc);
            e.bd    = br;
            exp_q.push_back(e);
        end
        #2;
        if (chk) begin
            o = exp_q.pop_front();
            check_val({tag, ".pc"},    bus.PC_out,                o.pc);
            check_val({tag, ".addr"},  bus.i_inst_addr,           o.pc);
            check_val({tag, ".instr"}, bus.Instr_out,             o.instr);
            check_val({tag, ".exc"},   {27'd0, bus.ExcCode_out},  {27'd0, o.exc});
            check_val({tag, ".bd"},    {31'd0, bus.BD_out},       {31'd0, o.bd});
        end
        @(posedge clk);
        if (rst)          model_pc = 32'h3000;
        else if (req)     model_pc = 32'h4180;
        else if (!we)     model_pc = model_pc;
        else if (eret)    model_pc = epc;
        else if (jmp)     model_pc = tgt;
        else              model_pc = model_pc + 32'd4;
        @(negedge clk);
    endtask

    initial begin
        model_pc = 32'hx;
        reset    = 1'b1;
        @(negedge clk);
        //    tag     rst req we eret epc    jmp tgt           br chk
        step("rst",   1, 0, 1, 0, 32'h0, 0, 32'h0,          0, 0);
        step("run0",  0, 0, 1, 0, 32'h0, 0, 32'h0,          0, 1);
        step("run1",  0, 0, 1, 0, 32'h0, 0, 32'h0,          0, 1);
        step("run2",  0, 0, 1, 0, 32'h0, 0, 32'h0,          0, 1);
        step("run3",  0, 0, 1, 0, 32'h0, 0, 32'h0,          0, 1);
        // PC = 0x3010: stall with a pending jump, then release
        step("stl0",  0, 0, 0, 0, 32'h0, 1, 32'h3100,       0, 1);
        step("stl1",  0, 0, 0, 0, 32'h0, 1, 32'h3100,       0, 1);
        step("jmp",   0, 0, 1, 0, 32'h0, 1, 32'h3100,       1, 1);
        step("tmis",  0, 0, 1, 0, 32'h0, 1, 32'h3102,       1, 1);
        step("thi",   0, 0, 1, 0, 32'h0, 1, 32'h7000,       0, 1);
        step("tedge", 0, 0, 1, 0, 32'h0, 1, 32'h6ffc,       0, 1);
        step("tlo",   0, 0, 1, 0, 32'h0, 1, 32'h2ffc,       0, 1);
        step("to3200",0, 0, 1, 0, 32'h0, 1, 32'h3200,       0, 1);
        step("req",   0, 1, 0, 0, 32'h0, 1, 32'h3300,       0, 1);
        step("eret",  0, 0, 1, 1, 32'h3204, 0, 32'h0,       0, 1);
        step("eretst",0, 0, 0, 1, 32'h3208, 0, 32'h0,       0, 1);
        step("eretjw",0, 0, 1, 1, 32'h3300, 1, 32'h3400,    0, 1);
        step("wrap0", 0, 0, 1, 0, 32'h0, 1, 32'hffff_fffc,  0, 1);
        step("wrap1", 0, 0, 1, 0, 32'h0, 0, 32'h0,          0, 1);
        step("wrap2", 0, 0, 1, 0, 32'h0, 1, 32'h4180,       0, 1);
        step("to4184",0, 0, 1, 0, 32'h0, 0, 32'h0,          0, 1);
        step("rstreq",1, 1, 0, 0, 32'h0, 1, 32'h5000,       1, 1);
        step("post",  0, 0, 1, 0, 32'h0, 0, 32'h0,          0, 1);
        step("post1", 0, 0, 1, 0, 32'h0, 0, 32'h0,          0, 1);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
